// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron stream driver.
package lif_pkg;

  localparam int LIF_BYTE_W = 8;

  // Control-pin encodings on the neuron side
  localparam logic LIF_SEL_WEIGHTS = 1'b1;  // uio_in[0]: 1 = weight register
  localparam logic LIF_MODE_RUN    = 1'b1;  // uio_in[1]: 1 = integrate, 0 = shift

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_X = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } lif_drv_state_t;

  // Byte index width, never narrower than one bit
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/lif_stream_driver_if.sv
// Neuron-side pin bundle: byte bus and control out, spike back.
interface lif_stream_driver_if;
  import lif_pkg::*;

  logic [LIF_BYTE_W-1:0] lif_data;
  logic                  lif_sel_w;
  logic                  lif_run;
  logic                  spike_in;

  modport master (output lif_data, output lif_sel_w, output lif_run, input spike_in);
  modport slave  (input lif_data, input lif_sel_w, input lif_run, output spike_in);

endinterface

// File: rtl/lif_byte_serializer.sv
// Shadow register for one parallel vector plus an MSB-first byte mux.
module lif_byte_serializer
  import lif_pkg::*;
#(
  parameter int NBYTES = 8,
  parameter int IDX_W  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [NBYTES*LIF_BYTE_W-1:0] din,
  input  logic [IDX_W-1:0]             idx,
  output logic [LIF_BYTE_W-1:0]        byte_out
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  logic [NBYTES*LIF_BYTE_W-1:0] shadow;
  logic [IDX_W-1:0]             sel;

  // Capture the vector when a transaction is accepted
  always_ff @(posedge clk) begin
    if (reset)     shadow <= '0;
    else if (load) shadow <= din;
  end

  // Index 0 selects the most significant byte
  always_comb begin
    sel      = LAST - idx;
    byte_out = shadow[int'(sel)*LIF_BYTE_W +: LIF_BYTE_W];
  end

endmodule

// File: rtl/lif_stream_driver.sv
// Host-side transmitter for the LIF neuron byte-serial load interface.
// Optional build macro: LIF_DRV_SPIKE_TRACE_EN adds a 16-bit spike history.
//
//   state   | meaning
//   IDLE    | neuron free-runs, waiting for start
//   LOAD_W  | shifting weight bytes, MSB byte first
//   LOAD_X  | shifting input bytes, MSB byte first
//   RUN     | integrate mode, counting returned spikes
//   DONE    | one-cycle completion pulse
module lif_stream_driver
  import lif_pkg::*;
#(
  parameter int N_STAGES = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_weights,
  input  logic [2**N_STAGES-1:0] weights,
  input  logic [2**N_STAGES-1:0] x_vec,
  input  logic [7:0]            run_cycles,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            spike_count,
`ifdef LIF_DRV_SPIKE_TRACE_EN
  output logic [15:0]           spike_trace,
`endif
  lif_stream_driver_if.master   lif
);

  localparam int INPUTS = 2**N_STAGES;
  localparam int NBYTES = INPUTS / 8;
  localparam int IDX_W  = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  lif_drv_state_t        state, state_next;
  logic [IDX_W-1:0]      idx;
  logic [7:0]            run_cnt;
  logic                  accept;
  logic [LIF_BYTE_W-1:0] w_byte, x_byte;

  assign accept = (state == ST_IDLE) && start;

  lif_byte_serializer #(.NBYTES(NBYTES), .IDX_W(IDX_W)) u_ser_w (
    .clk(clk), .reset(reset), .load(accept), .din(weights), .idx(idx), .byte_out(w_byte)
  );

  lif_byte_serializer #(.NBYTES(NBYTES), .IDX_W(IDX_W)) u_ser_x (
    .clk(clk), .reset(reset), .load(accept), .din(x_vec), .idx(idx), .byte_out(x_byte)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; run_cnt already holds the latched run length
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = load_weights ? ST_LOAD_W : ST_LOAD_X;
      ST_LOAD_W: if (idx == LAST) state_next = ST_LOAD_X;
      ST_LOAD_X: if (idx == LAST) state_next = (run_cnt == 8'd0) ? ST_DONE : ST_RUN;
      ST_RUN:    if (run_cnt == 8'd1) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state and shadow bytes only
  always_comb begin
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
    lif.lif_run   = LIF_MODE_RUN;
    lif.lif_sel_w = ~LIF_SEL_WEIGHTS;
    lif.lif_data  = '0;
    case (state)
      ST_LOAD_W: begin
        lif.lif_run   = ~LIF_MODE_RUN;
        lif.lif_sel_w = LIF_SEL_WEIGHTS;
        lif.lif_data  = w_byte;
      end
      ST_LOAD_X: begin
        lif.lif_run   = ~LIF_MODE_RUN;
        lif.lif_data  = x_byte;
      end
      default: ;
    endcase
  end

  // Byte index, run down-counter and saturating spike counter
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      run_cnt     <= '0;
      spike_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx         <= '0;
            run_cnt     <= run_cycles;
            spike_count <= '0;
          end
        end
        ST_LOAD_W, ST_LOAD_X: begin
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        ST_RUN: begin
          run_cnt <= run_cnt - 8'd1;
          if (lif.spike_in && (spike_count != 8'hFF))
            spike_count <= spike_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef LIF_DRV_SPIKE_TRACE_EN
  // Recent spike history, newest sample in bit 0
  always_ff @(posedge clk) begin
    if (reset || accept)      spike_trace <= '0;
    else if (state == ST_RUN) spike_trace <= {spike_trace[14:0], lif.spike_in};
  end
`endif

endmodule

// File: tb/tb_lif_stream_driver.sv
// Directed self-checking bench for lif_stream_driver with a simple LIF neuron model.
module tb_lif_stream_driver;

  localparam int INPUTS = 64;
  localparam int THRESH = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        load_weights;
  logic [63:0] weights;
  logic [63:0] x_vec;
  logic [7:0]  run_cycles;
  logic        busy, done;
  logic [7:0]  spike_count;
`ifdef LIF_DRV_SPIKE_TRACE_EN
  logic [15:0] spike_trace;
`endif

  lif_stream_driver_if bus ();

  lif_stream_driver #(.N_STAGES(6)) dut (
    .clk(clk), .reset(rst), .start(start), .load_weights(load_weights),
    .weights(weights), .x_vec(x_vec), .run_cycles(run_cycles),
    .busy(busy), .done(done), .spike_count(spike_count),
`ifdef LIF_DRV_SPIKE_TRACE_EN
    .spike_trace(spike_trace),
`endif
    .lif(bus)
  );

  always #5 clk = ~clk;

  // Neuron model: shift bytes in at the low end in load mode; integrate +/-1 weights in run mode
  logic [63:0] nrn_w, nrn_x;
  int          nrn_v, nrn_sum;
  logic        nrn_spike;
  logic        force_en, force_val;

  assign bus.spike_in = force_en ? force_val : nrn_spike;

  always_comb begin
    nrn_sum = 0;
    for (int i = 0; i < INPUTS; i++)
      if (nrn_x[i]) nrn_sum = nrn_sum + (nrn_w[i] ? 1 : -1);
  end

  always @(posedge clk) begin
    if (rst) begin
      nrn_w <= '1; nrn_x <= '0; nrn_v <= 0; nrn_spike <= 1'b0;
    end else if (!bus.lif_run) begin
      if (bus.lif_sel_w) nrn_w <= {nrn_w[55:0], bus.lif_data};
      else               nrn_x <= {nrn_x[55:0], bus.lif_data};
      nrn_v <= 0; nrn_spike <= 1'b0;
    end else if (nrn_v + nrn_sum >= THRESH) begin
      nrn_v <= 0; nrn_spike <= 1'b1;
    end else begin
      nrn_v <= nrn_v + nrn_sum; nrn_spike <= 1'b0;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge; returns in cycle 1 of the transaction
  task automatic do_start(input logic lw, input logic [63:0] w, input logic [63:0] x, input logic [7:0] rc);
    load_weights = lw; weights = w; x_vec = x; run_cycles = rc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs until busy drops (bounded); returns busy length, done count and done cycle
  task automatic run_txn(input int limit, output int nbusy, output int ndone, output int done_at);
    nbusy = 0; ndone = 0; done_at = -1;
    while (busy === 1'b1 && nbusy < limit) begin
      nbusy++;
      if (done === 1'b1) begin ndone++; done_at = nbusy; end
      step();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_count"}, spike_count, 0);
    check({tag, "_data"},  bus.lif_data, 0);
    check({tag, "_sel_w"}, bus.lif_sel_w, 0);
    check({tag, "_run"},   bus.lif_run, 1);
  endtask

  initial begin
    int nbusy, ndone, done_at;
    logic [127:0] seq;
    logic [63:0]  x4;

    rst = 1'b1; start = 1'b0; load_weights = 1'b0; weights = '0; x_vec = '0;
    run_cycles = '0; force_en = 1'b0; force_val = 1'b0;
    repeat (3) step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();

    // Inputs only, all-ones x, default +1 weights, 10 run cycles: spikes sampled on edges 11,13,15,17
    do_start(1'b0, 64'h0, {64{1'b1}}, 8'd10);
    check("s2_c1_data", bus.lif_data, 8'hFF);
    check("s2_c1_sel", bus.lif_sel_w, 0);
    check("s2_c1_run", bus.lif_run, 0);
    run_txn(100, nbusy, ndone, done_at);
    check("s2_busy_len", nbusy, 19);
    check("s2_done_at", done_at, 19);
    check("s2_spikes", spike_count, 4);

    // Full load, run_cycles = 0
    seq = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    do_start(1'b1, seq[127:64], seq[63:0], 8'd0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("s1_data%0d", k), bus.lif_data, seq[127-8*k -: 8]);
      check($sformatf("s1_sel%0d", k), bus.lif_sel_w, (k < 8) ? 1 : 0);
      check($sformatf("s1_run%0d", k), bus.lif_run, 0);
      step();
    end
    check("s1_c17_done", done, 1);
    check("s1_c17_busy", busy, 1);
    check("s1_c17_run", bus.lif_run, 1);
    step();
    check("s1_c18_done", done, 0);
    check("s1_c18_busy", busy, 0);
    check("s1_nrn_w", nrn_w, 64'h0123456789ABCDEF);
    check("s1_nrn_x", nrn_x, 64'hFEDCBA9876543210);
    check("s1_count", spike_count, 0);

    // x = 0 for 255 run cycles: no spikes
    do_start(1'b0, 64'h0, 64'h0, 8'd255);
    run_txn(400, nbusy, ndone, done_at);
    check("s3_busy_len", nbusy, 264);
    check("s3_zero_count", spike_count, 0);

    // Spike forced high for the whole run
    force_en = 1'b1; force_val = 1'b1;
    do_start(1'b0, 64'h0, 64'h0, 8'd255);
    run_txn(400, nbusy, ndone, done_at);
    check("s3_sat_count", spike_count, 255);
    check("s3_sat_ndone", ndone, 1);
    force_en = 1'b0; force_val = 1'b0;
    step();
    check("s3_hold_count", spike_count, 255);

    // Ignored starts in LOAD_X/RUN/DONE and a mid-load x_vec change
    x4 = 64'h1122334455667788;
    do_start(1'b0, 64'h0, x4, 8'd3);
    check("s4_restart_clear", spike_count, 0);
    ndone = 0; done_at = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 8) check($sformatf("s4_data%0d", c), bus.lif_data, x4[71-8*c -: 8]);
      if (c == 13) check("s4_c13_busy", busy, 0);
      if (done === 1'b1) begin ndone++; done_at = c; end
      if (c == 2) x_vec = 64'h0;
      start = (c == 3 || c == 10 || c == 12);
      step();
    end
    start = 1'b0;
    check("s4_ndone", ndone, 1);
    check("s4_done_at", done_at, 12);

    // Reset in cycle 5 of LOAD_W
    do_start(1'b1, 64'hFFFF0000FFFF0000, 64'h0, 8'd2);
    repeat (4) step();
    check("s5_c5_sel", bus.lif_sel_w, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("s5_midreset");
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      step();
    end
    check("s5_no_activity", ndone, 0);
    do_start(1'b1, 64'hA5A5_5A5A_C3C3_3C3C, 64'h0F0F_0F0F_0F0F_0F0F, 8'd2);
    run_txn(100, nbusy, ndone, done_at);
    check("s5_busy_len", nbusy, 19);
    check("s5_done_at", done_at, 19);
    check("s5_nrn_w", nrn_w, 64'hA5A5_5A5A_C3C3_3C3C);
    check("s5_nrn_x", nrn_x, 64'h0F0F_0F0F_0F0F_0F0F);

`ifdef LIF_DRV_SPIKE_TRACE_EN
    // Spike pattern 1,0,1,1 presented during RUN cycles 9..12
    force_en = 1'b1; force_val = 1'b0;
    do_start(1'b0, 64'h0, 64'h0, 8'd4);
    check("s6_trace_clear", spike_trace, 16'h0000);
    for (int c = 1; c <= 13; c++) begin
      force_val = (c == 9 || c == 11 || c == 12);
      step();
    end
    force_en = 1'b0; force_val = 1'b0;
    check("s6_busy", busy, 0);
    check("s6_trace", spike_trace, 16'h000B);
    check("s6_count", spike_count, 3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
